// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_NUM_RD   = 2;

    // Address width for a register count; never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register mux, write forwarding and busy gating.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_w(NUM_REGS)
) (
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic is_zero;
    logic fwd_hit;

    assign is_zero = ZERO_REG && (rd_addr == '0);
    assign fwd_hit = wr_en && (wr_addr == rd_addr) && !is_zero;

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (rd_en && !is_zero) begin
            if (fwd_hit) begin
                rd_data = wr_data;
            end else begin
                rd_data = regs[rd_addr];
                rd_busy = busy[rd_addr];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy (scoreboard) bits and write forwarding.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_w(NUM_REGS),
    localparam int unsigned CW      = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [CW-1:0]            busy_count
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CW-1:0]       count_d;
    logic                wr_ok;
    logic                alloc_ok;

    assign wr_ok    = wr_en && !(ZERO_REG && (wr_addr == '0));
    assign alloc_ok = alloc_en && !(ZERO_REG && (alloc_addr == '0));

    // Allocation is applied after the write clear so a same-address alloc wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (alloc_ok) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (rst) begin
            busy_d = '0;
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        busy_q     <= busy_d;
        busy_count <= count_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .rd_en   (rd_en[p]),
            .rd_addr (rd_addr[p*AW +: AW]),
            .regs    (regs),
            .busy    (busy_q),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_sb;

    localparam int unsigned DW  = 32;
    localparam int unsigned NR  = 32;
    localparam int unsigned NRD = 2;
    localparam int unsigned AW  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [AW:0]       busy_count;

    regfile_sb #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NRD),
        .ZERO_REG (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    localparam int K_DATA  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_COUNT = 2;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    // Monitor: every expectation stamped for this cycle is compared mid-cycle.
    exp_t        e;
    logic [31:0] act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_DATA:  act = rd_data[e.port*DW +: DW];
                K_BUSY:  act = 32'(rd_busy[e.port]);
                default: act = 32'(busy_count);
            endcase
            n_tests++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, due %0d)",
                         e.name, act, e.exp, cyc, e.cyc);
            end
        end
    end

    task automatic expect_val(input string name, input int kind, input int port,
                              input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.kind = kind;
        x.port = port;
        x.exp  = val;
        x.cyc  = cyc;
        sb.push_back(x);
    endtask

    // Advance one cycle and drive a fresh input vector shortly after the edge.
    task automatic step(input logic r, input logic we, input int wa, input logic [31:0] wd,
                        input logic ae, input int aa,
                        input logic [1:0] re, input int ra0, input int ra1);
        @(posedge clk);
        #1;
        rst        = r;
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = wd;
        alloc_en   = ae;
        alloc_addr = AW'(aa);
        rd_en      = re;
        rd_addr    = {AW'(ra1), AW'(ra0)};
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; rd_en = '0; rd_addr = '0;
        repeat (2) @(posedge clk);

        step(0, 0, 0, 0, 0, 0, 2'b11, 5, 6);
        expect_val("reset_count", K_COUNT, 0, 0);
        expect_val("reset_r5", K_DATA, 0, 0);
        expect_val("reset_busy0", K_BUSY, 0, 0);
        expect_val("reset_r6", K_DATA, 1, 0);

        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 2'b01, 1, 0);
        expect_val("other_reg_during_wr", K_DATA, 0, 0);

        step(0, 0, 0, 0, 0, 0, 2'b01, 5, 0);
        expect_val("r5_next_cycle", K_DATA, 0, 32'hDEADBEEF);
        expect_val("r5_not_busy", K_BUSY, 0, 0);
        #1;
        n_tests++;
        if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL direct_r5: got 0x%08h", rd_data[0 +: DW]);
        end

        step(0, 1, 7, 32'h12345678, 0, 0, 2'b11, 5, 7);
        expect_val("fwd_p1_r7", K_DATA, 1, 32'h12345678);
        expect_val("p0_r5_while_fwd", K_DATA, 0, 32'hDEADBEEF);
        #1;
        n_tests++;
        if (rd_data[DW +: DW] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL direct_fwd_r7: got 0x%08h", rd_data[DW +: DW]);
        end

        step(0, 1, 0, 32'hFFFFFFFF, 1, 0, 2'b11, 0, 7);
        expect_val("r0_no_fwd", K_DATA, 0, 0);
        expect_val("r7_stored", K_DATA, 1, 32'h12345678);

        step(0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        expect_val("r0_reads_zero", K_DATA, 0, 0);
        expect_val("r0_alloc_count", K_COUNT, 0, 0);

        step(0, 0, 0, 0, 1, 3, 2'b01, 3, 0);
        expect_val("alloc3_same_cycle_busy", K_BUSY, 0, 0);

        step(0, 0, 0, 0, 0, 0, 2'b01, 3, 0);
        expect_val("alloc3_busy", K_BUSY, 0, 1);
        expect_val("alloc3_count", K_COUNT, 0, 1);
        #1;
        n_tests++;
        if (rd_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_alloc3_busy: got %b", rd_busy[0]);
        end

        step(0, 1, 3, 32'h000000A5, 0, 0, 2'b01, 3, 0);
        expect_val("wr3_fwd_data", K_DATA, 0, 32'hA5);
        expect_val("wr3_fwd_busy", K_BUSY, 0, 0);
        expect_val("wr3_count_before", K_COUNT, 0, 1);

        step(0, 0, 0, 0, 0, 0, 2'b01, 3, 0);
        expect_val("wr3_count_after", K_COUNT, 0, 0);
        expect_val("r3_stored", K_DATA, 0, 32'hA5);

        step(0, 1, 9, 32'h55, 1, 9, 2'b10, 0, 9);
        expect_val("alloc_wr9_fwd", K_DATA, 1, 32'h55);
        expect_val("alloc_wr9_fwd_busy", K_BUSY, 1, 0);

        step(0, 0, 0, 0, 0, 0, 2'b10, 5, 9);
        expect_val("r9_data", K_DATA, 1, 32'h55);
        expect_val("r9_busy", K_BUSY, 1, 1);
        expect_val("r9_count", K_COUNT, 0, 1);
        expect_val("disabled_port_data", K_DATA, 0, 0);
        expect_val("disabled_port_busy", K_BUSY, 0, 0);
        #1;
        n_tests++;
        if (busy_count !== (AW+1)'(1)) begin
            n_fail++;
            $display("FAIL direct_r9_count: got %0d", busy_count);
        end

        step(0, 0, 0, 0, 1, 1, 2'b00, 0, 0);
        expect_val("count_1", K_COUNT, 0, 1);
        step(0, 0, 0, 0, 1, 2, 2'b00, 0, 0);
        expect_val("count_2", K_COUNT, 0, 2);
        step(0, 0, 0, 0, 1, 3, 2'b00, 0, 0);
        expect_val("count_3", K_COUNT, 0, 3);
        step(0, 0, 0, 0, 1, 4, 2'b00, 0, 0);
        expect_val("count_4", K_COUNT, 0, 4);
        step(0, 0, 0, 0, 1, 9, 2'b00, 0, 0);
        expect_val("count_5", K_COUNT, 0, 5);
        step(0, 1, 6, 32'h66, 0, 0, 2'b00, 0, 0);
        expect_val("realloc_busy_no_change", K_COUNT, 0, 5);

        step(1, 1, 2, 32'h77, 0, 0, 2'b11, 5, 9);
        expect_val("in_reset_r5_stored", K_DATA, 0, 32'hDEADBEEF);
        expect_val("in_reset_r9_busy", K_BUSY, 1, 1);
        expect_val("in_reset_count", K_COUNT, 0, 5);

        step(0, 0, 0, 0, 0, 0, 2'b11, 5, 2);
        expect_val("post_rst_count", K_COUNT, 0, 0);
        expect_val("post_rst_r5", K_DATA, 0, 0);
        expect_val("post_rst_r2", K_DATA, 1, 0);
        expect_val("post_rst_r2_busy", K_BUSY, 1, 0);
        #1;
        n_tests++;
        if (busy_count !== '0) begin
            n_fail++;
            $display("FAIL direct_post_rst_count: got %0d", busy_count);
        end

        step(0, 0, 0, 0, 0, 0, 2'b11, 9, 9);
        expect_val("post_rst_r9_p0", K_DATA, 0, 0);
        expect_val("post_rst_r9_busy", K_BUSY, 1, 0);
        expect_val("post_rst_r9_p1", K_DATA, 1, 0);

        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked, expected 0x%08h", e.name, e.exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count, power of two, minimum 2; AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports, 1 to 4.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hard-wired to zero.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have ports wr_en (input, 1, write strobe), wr_addr (input, AW, write target) and wr_data (input, DATA_W, write value).
REQ-008 SHALL have ports alloc_en (input, 1, mark register pending) and alloc_addr (input, AW, register to mark).
REQ-009 SHALL have ports rd_en (input, NUM_RD, per-port read enable) and rd_addr (input, NUM_RD*AW, packed; port i at bits [i*AW +: AW]).
REQ-010 SHALL have ports rd_data (output, NUM_RD*DATA_W, packed per port) and rd_busy (output, NUM_RD, operand not yet valid).
REQ-011 SHALL have port busy_count (output, log2(NUM_REGS)+1, number of pending registers, registered).

Function
REQ-012 SHALL commit wr_data to regs[wr_addr] at the clock edge when wr_en=1; otherwise the register contents SHALL hold.
REQ-013 SHALL, with ZERO_REG=1, ignore writes and allocations to address 0 and return 0 on every read of address 0.
REQ-014 SHALL drive read ports combinationally (zero-latency); rd_data for port i = 0 and rd_busy[i] = 0 while rd_en[i]=0.
REQ-015 SHALL forward the write port: when wr_en=1 and wr_addr equals rd_addr of port i (excluding address 0 under ZERO_REG), rd_data for port i = wr_data in the same cycle.
REQ-016 SHALL keep a busy bit per register; alloc_en sets busy[alloc_addr] at the next edge; wr_en clears busy[wr_addr] at the next edge.
REQ-017 SHALL, on simultaneous alloc_en and wr_en to the same address, leave the busy bit set (the new allocation wins) and still commit the data.
REQ-018 SHALL drive rd_busy[i] = rd_en[i] AND busy[rd_addr_i] AND NOT (a forwarding hit on port i).
REQ-019 SHALL update busy_count every cycle to the next-state popcount of the busy bits; it ranges 0..NUM_REGS (NUM_REGS-1 when ZERO_REG=1).
REQ-020 SHALL allow alloc_en on an already-busy register (no count change) and wr_en on a non-busy register (normal write, no count change).
REQ-021 SHALL let any number of read ports address the same register and return identical data.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, clear all registers to 0, clear all busy bits and set busy_count to 0; rst SHALL override wr_en and alloc_en in the same cycle.
REQ-023 SHALL treat reset asserted mid-operation identically to REQ-022; pending allocations are discarded.
REQ-024 SHALL keep read outputs combinational during reset, reflecting the stored contents.

Structure
REQ-025 SHALL take default parameter constants (DATA_W, NUM_REGS, NUM_RD) from shared package regfile_pkg; regfile_pkg SHALL also define the helper that computes AW.
REQ-026 SHALL implement each read port (read mux, forwarding compare, busy gating) as one sub-module, regfile_rd_port, instantiated NUM_RD times through a generate loop.

Verification
REQ-027 SHALL cover: reset; write reg5=0xDEADBEEF; read port0 addr5 next cycle -> 0xDEADBEEF, rd_busy=0.
REQ-028 SHALL cover: wr_en addr7=0x12345678 with port1 reading addr7 in the same cycle -> rd_data port1 = 0x12345678 that cycle.
REQ-029 SHALL cover: write addr0=0xFFFFFFFF and alloc addr0 with ZERO_REG=1 -> reading addr0 returns 0, busy_count=0.
REQ-030 SHALL cover: alloc addr3 -> busy_count=1 and rd_busy=1 on a port reading 3; write addr3=0xA5 -> forwarded same cycle with rd_busy=0, then busy_count=0.
REQ-031 SHALL cover: simultaneous alloc addr9 and write addr9=0x55 -> reg9=0x55, busy[9]=1, busy_count=1.
REQ-032 SHALL cover: allocate regs 1..4, assert rst together with wr_en addr2 -> all regs 0, busy_count=0 after the edge.
